// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth-table scanner.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    localparam int unsigned DEF_N_WIDTH = 4;
    localparam int unsigned TT_W        = 2 ** DEF_N_WIDTH;
    localparam int unsigned LAST_IDX    = TT_W - 1;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle counter: load clears it, inc steps it, term flags the last settle cycle.
module tt_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic term
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == CNT_LAST);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps N through all codes, samples F after a settle time, builds tt and ones_cnt.
// Optional expected-table checker enabled by defining TT_CHECK_EN.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned N_WIDTH       = DEF_N_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [N_WIDTH-1:0]        n_out,
    input  logic                      f_in,
    output logic                      busy,
    output logic                      done,
    output logic [(2**N_WIDTH)-1:0]   tt,
    output logic [N_WIDTH:0]          ones_cnt
`ifdef TT_CHECK_EN
    ,
    input  logic [(2**N_WIDTH)-1:0]   exp_tt,
    output logic                      mismatch,
    output logic [N_WIDTH-1:0]        fail_idx
`endif
);

    localparam int unsigned TBL_W = 2 ** N_WIDTH;
    localparam logic [N_WIDTH-1:0] N_LAST = N_WIDTH'(TBL_W - 1);

    state_e               state_q, state_d;
    logic [N_WIDTH-1:0]   n_q, n_d;
    logic [TBL_W-1:0]     tt_q, tt_d;
    logic [N_WIDTH:0]     ones_q, ones_d;
    logic                 tmr_load;
    logic                 tmr_inc;
    logic                 tmr_term;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .inc   (tmr_inc),
        .term  (tmr_term)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        tt_d     = tt_q;
        ones_d   = ones_q;
        tmr_load = 1'b0;
        tmr_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    n_d      = '0;
                    tt_d     = '0;
                    ones_d   = '0;
                    tmr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_term) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            SAMPLE: begin
                tt_d[n_q] = f_in;
                ones_d    = ones_q + {{N_WIDTH{1'b0}}, f_in};
                // n_out holds the last code through DONE rather than wrapping
                if (n_q == N_LAST) begin
                    state_d = DONE;
                end else begin
                    n_d      = n_q + 1'b1;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
        end
    end

    assign n_out    = n_q;
    assign busy     = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done     = (state_q == DONE);
    assign tt       = tt_q;
    assign ones_cnt = ones_q;

`ifdef TT_CHECK_EN
    logic [TBL_W-1:0]   exp_q, exp_d;
    logic               mismatch_q, mismatch_d;
    logic [N_WIDTH-1:0] fail_idx_q, fail_idx_d;
    logic [TBL_W-1:0]   diff;
    logic               found;

    // Result is computed from the final table on the last SAMPLE edge so it is valid alongside done
    always_comb begin
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
        fail_idx_d = fail_idx_q;
        diff       = tt_d ^ exp_q;
        found      = 1'b0;
        if (state_q == IDLE && start) begin
            exp_d      = exp_tt;
            mismatch_d = 1'b0;
            fail_idx_d = '0;
        end else if (state_q == SAMPLE && n_q == N_LAST) begin
            mismatch_d = |diff;
            fail_idx_d = '0;
            for (int unsigned i = 0; i < TBL_W; i++) begin
                if (!found && diff[i]) begin
                    fail_idx_d = N_WIDTH'(i);
                    found      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign mismatch = mismatch_q;
    assign fail_idx = fail_idx_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: SETTLE_CYCLES=2 (dut0) and SETTLE_CYCLES=1 (dut1).
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [3:0]  n0, n1;
    logic        f0, f1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] tt0, tt1;
    logic [4:0]  ones0, ones1;
    int          model_sel;
    int          ncmp = 0;
    int          nfail = 0;
    int          dones0 = 0;
    int          dones1 = 0;
    logic [15:0] exp_tt_v;
`ifdef TT_CHECK_EN
    logic        mm0, mm1;
    logic [3:0]  fi0, fi1;
`endif

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  ones;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic fmodel(int sel, logic [3:0] n);
        case (sel)
            0:       return (n == 2) || (n == 3) || (n == 5) || (n == 7) || (n == 11) || (n == 13);
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign f0 = fmodel(model_sel, n0);
    assign f1 = fmodel(model_sel, n1);

    truth_table_scanner #(.SETTLE_CYCLES(2), .N_WIDTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .n_out(n0), .f_in(f0),
        .busy(busy0), .done(done0), .tt(tt0), .ones_cnt(ones0)
`ifdef TT_CHECK_EN
        , .exp_tt(exp_tt_v), .mismatch(mm0), .fail_idx(fi0)
`endif
    );

    truth_table_scanner #(.SETTLE_CYCLES(1), .N_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .n_out(n1), .f_in(f1),
        .busy(busy1), .done(done1), .tt(tt1), .ones_cnt(ones1)
`ifdef TT_CHECK_EN
        , .exp_tt(exp_tt_v), .mismatch(mm1), .fail_idx(fi1)
`endif
    );

    always @(posedge clk) begin
        if (done0) dones0 <= dones0 + 1;
        if (done1) dones1 <= dones1 + 1;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One full scan on dut0 (sel=0) or dut1 (sel=1); again>0 pulses a stray start at that edge.
    task automatic run_scan(int sel, int model, int again);
        int settle;
        int prev_dones;
        int exp_n;
        bit found;
        exp_t e;
        exp_t got;
        settle    = sel ? 1 : 2;
        model_sel = model;
        e.tt      = '0;
        e.ones    = '0;
        for (int n = 0; n < 16; n++) begin
            e.tt[n] = fmodel(model, 4'(n));
            e.ones  = e.ones + 5'(fmodel(model, 4'(n)));
        end
        sb.push_back(e);
        prev_dones = sel ? dones1 : dones0;
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        found  = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (k == again) begin
                if (sel) start1 = 1'b1; else start0 = 1'b1;
            end
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
            exp_n = k / (settle + 1);
            if (exp_n > 15) exp_n = 15;
            check("n_step", sel ? n1 : n0, exp_n);
            if (k == 1) check("busy_mid", sel ? busy1 : busy0, 1);
            if (sel ? done1 : done0) begin
                found = 1'b1;
                check("done_edge", k, 16 * (settle + 1));
                check("busy_at_done", sel ? busy1 : busy0, 0);
                got = sb.pop_front();
                check("tt", sel ? tt1 : tt0, got.tt);
                check("ones_cnt", sel ? ones1 : ones0, got.ones);
`ifdef TT_CHECK_EN
                begin
                    logic [15:0] d;
                    logic [3:0]  fi;
                    d  = got.tt ^ exp_tt_v;
                    fi = '0;
                    for (int i = 15; i >= 0; i--) if (d[i]) fi = 4'(i);
                    check("mismatch", sel ? mm1 : mm0, (d != 0));
                    check("fail_idx", sel ? fi1 : fi0, fi);
                end
`endif
                break;
            end
        end
        check("done_seen", found, 1);
        @(posedge clk);
        #1;
        check("done_pulse_len", sel ? done1 : done0, 0);
        check("done_count", (sel ? dones1 : dones0) - prev_dones, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        model_sel = 0;
        exp_tt_v = 16'h28AC;
        #2;
        check("rst_n_out", {n1, n0}, 0);
        check("rst_busy_done", {busy1, busy0, done1, done0}, 0);
        check("rst_tt", {tt1, tt0}, 0);
        check("rst_ones", {ones1, ones0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Prime model, then back-to-back scans starting on the IDLE cycle after DONE
        run_scan(0, 0, 0);
        exp_tt_v = 16'hFFFF;
        run_scan(0, 1, 0);
        exp_tt_v = 16'h0000;
        run_scan(0, 2, 0);

        // Results hold while idle
        repeat (5) @(negedge clk);
        check("tt_hold", tt0, 16'h0000);
        check("busy_idle", busy0, 0);

        exp_tt_v = 16'h28AC;
        run_scan(0, 0, 10);

        // Reset mid-scan
        model_sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("abort_n_out", n0, 0);
        check("abort_busy_done", {busy0, done0}, 0);
        check("abort_tt", tt0, 0);
        check("abort_ones", ones0, 0);
        begin
            int d0;
            d0 = dones0;
            repeat (60) @(posedge clk);
            #1;
            check("abort_no_done", dones0 - d0, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(0, 0, 0);

        // Short settle instance
        run_scan(1, 0, 0);

`ifdef TT_CHECK_EN
        exp_tt_v = 16'h28A8;
        run_scan(0, 0, 0);
        run_scan(1, 0, 0);
        exp_tt_v = 16'h28AC;
        run_scan(0, 0, 0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
